sha3_theta_column_parity: RTL

- First stage of the theta step. Receives the 25-lane Keccak state one row (5 lanes) per beat, buffers the whole state, and accumulates the five column parities C[x] = A[x,0]^A[x,1]^A[x,2]^A[x,3]^A[x,4].
- When a full state has arrived, presents C[0..4] (the `term` vector consumed by sha3_theta_elt_evaluator) together with the buffered state, under a valid/ready handshake.
- Sits between the round input mux and sha3_theta_elt_evaluator.

---
 rtl/sha3_pkg.sv | 21 ++
 rtl/sha3_theta_column_parity.sv | 93 +++++++++
 2 files changed

// File: rtl/sha3_pkg.sv
// Shared Keccak-f[1600] types and lane indexing helpers.
package sha3_pkg;

  localparam int SHA3_COLS  = 5;
  localparam int SHA3_ROWS  = 5;
  localparam int SHA3_LANES = 25;

  typedef logic [63:0] lane_t;
  typedef lane_t [SHA3_COLS-1:0]  row_t;
  typedef lane_t [SHA3_LANES-1:0] state_t;

  typedef enum logic {
    ACCUM,
    FULL
  } theta_fsm_t;

  function automatic int lane_index(input int x, input int y);
    return x + SHA3_COLS * y;
  endfunction

endpackage

// File: rtl/sha3_theta_column_parity.sv
// Theta stage 1: buffers a row-serial Keccak state and accumulates column parities C[x].
module sha3_theta_column_parity
  import sha3_pkg::*;
#(
  parameter STYLE = "basic"
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   in_valid,
  output logic   in_ready,
  input  row_t   in_row,
  output logic   out_valid,
  input  logic   out_ready,
  output row_t   term,
  output state_t state
);

  generate
    if (STYLE != "basic") begin : g_style_check
      $error("Logic style unsupported.");
    end
  endgenerate

  theta_fsm_t fsm_reg;
  logic [2:0] r_reg;
  logic       out_valid_reg;
  row_t       acc_reg;
  row_t       acc_next;
  state_t     state_reg;
  state_t     state_next;
  logic       load;

  // In FULL the handoff edge may take row 0 of the next block; r_reg is 0 there.
  assign in_ready = rst && ((fsm_reg == ACCUM) || out_ready);
  assign load     = in_valid && in_ready;

  genvar gi, gj;
  generate
    for (gi = 0; gi < SHA3_COLS; gi++) begin : g_acc
      assign acc_next[gi] = (r_reg == 3'd0) ? in_row[gi] : (acc_reg[gi] ^ in_row[gi]);
    end
    for (gi = 0; gi < SHA3_ROWS; gi++) begin : g_row
      for (gj = 0; gj < SHA3_COLS; gj++) begin : g_col
        assign state_next[lane_index(gj, gi)] =
          (r_reg == 3'(gi)) ? in_row[gj] : state_reg[lane_index(gj, gi)];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      fsm_reg       <= ACCUM;
      r_reg         <= 3'd0;
      out_valid_reg <= 1'b0;
      acc_reg       <= '0;
      state_reg     <= '0;
    end else begin
      if (load) begin
        acc_reg   <= acc_next;
        state_reg <= state_next;
      end
      case (fsm_reg)
        ACCUM: begin
          if (in_valid) begin
            if (r_reg == 3'd4) begin
              fsm_reg       <= FULL;
              r_reg         <= 3'd0;
              out_valid_reg <= 1'b1;
            end else begin
              r_reg <= r_reg + 3'd1;
            end
          end
        end
        FULL: begin
          if (out_ready) begin
            fsm_reg       <= ACCUM;
            out_valid_reg <= 1'b0;
            r_reg         <= in_valid ? 3'd1 : 3'd0;
          end
        end
        default: begin
          fsm_reg <= ACCUM;
          r_reg   <= 3'd0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_reg;
  assign term      = acc_reg;
  assign state     = state_reg;

endmodule
